// File: rtl/axis_mon_pkg.sv
// Shared definitions for the AXI4-Stream frame monitor: tuser flag positions,
// monitor FSM states and the bit positions of the sticky error vector.
package axis_mon_pkg;

  localparam int TUSER_SOF = 0;
  localparam int TUSER_EOF = 1;
  localparam int TUSER_SOL = 2;
  localparam int TUSER_EOL = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LINE = 2'd1,
    GAP  = 2'd2
  } mon_state_t;

  localparam int ERR_W                  = 7;
  localparam int ERR_SOF_UNEXPECTED     = 0;
  localparam int ERR_DATA_OUTSIDE_FRAME = 1;
  localparam int ERR_LINE_LENGTH        = 2;
  localparam int ERR_LINE_COUNT         = 3;
  localparam int ERR_TLAST_MISMATCH     = 4;
  localparam int ERR_TIMEOUT            = 5;
  localparam int ERR_SOL_MISSING        = 6;

endpackage

// File: rtl/axis_mon_sat_counter.sv
// Saturating up-counter with synchronous clear, load-one and increment.
// Priority is clear > load-one > increment; the count sticks at all-ones.
// Ports:
//   clk_i, rst_i : clock and synchronous active-high reset
//   clr_i        : load zero
//   ld1_i        : load one
//   inc_i        : increment (saturating)
//   q_o          : current count
module axis_mon_sat_counter #(
  parameter int W = 16
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         clr_i,
  input  logic         ld1_i,
  input  logic         inc_i,
  output logic [W-1:0] q_o
);

  function automatic logic [W-1:0] sat_inc(input logic [W-1:0] v);
    return (&v) ? v : v + W'(1);
  endfunction

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)      cnt_d = '0;
    else if (ld1_i) cnt_d = W'(1);
    else if (inc_i) cnt_d = sat_inc(cnt_q);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign q_o = cnt_q;

endmodule

// File: rtl/axis_frame_monitor.sv
// Passive AXI4-Stream video frame monitor. Watches beats on the sniffed
// stream, checks line/frame geometry against the cfg inputs, keeps a frame
// count and an XOR checksum, and raises sticky protocol error flags.
// Ports:
//   aclk, aclk_reset           : clock, synchronous active-high reset
//   s_axis_*                   : sniffed stream (inputs only, never driven)
//   cfg_enable                 : 0 forces IDLE and freezes counting
//   cfg_line_beats/frame_lines : expected geometry
//   cfg_timeout                : stall limit in cycles, 0 disables watchdog
//   err_clear                  : clears err_sticky (a same-cycle set wins)
//   in_frame, frame_done, frame_count, last_line_beats, last_frame_lines,
//   frame_checksum, err_sticky, err_pulse : registered status outputs
module axis_frame_monitor
  import axis_mon_pkg::*;
#(
  parameter int AXIS_DATA_WIDTH = 64,
  parameter int AXIS_USER_WIDTH = 4,
  parameter int CNT_WIDTH       = 16,
  parameter int FRAME_CNT_WIDTH = 32
) (
  input  logic                       aclk,
  input  logic                       aclk_reset,
  input  logic                       s_axis_tvalid,
  input  logic                       s_axis_tready,
  input  logic [AXIS_DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [AXIS_USER_WIDTH-1:0] s_axis_tuser,
  input  logic                       s_axis_tlast,
  input  logic                       cfg_enable,
  input  logic [CNT_WIDTH-1:0]       cfg_line_beats,
  input  logic [CNT_WIDTH-1:0]       cfg_frame_lines,
  input  logic [CNT_WIDTH-1:0]       cfg_timeout,
  input  logic                       err_clear,
  output logic                       in_frame,
  output logic                       frame_done,
  output logic [FRAME_CNT_WIDTH-1:0] frame_count,
  output logic [CNT_WIDTH-1:0]       last_line_beats,
  output logic [CNT_WIDTH-1:0]       last_frame_lines,
  output logic [AXIS_DATA_WIDTH-1:0] frame_checksum,
  output logic [ERR_W-1:0]           err_sticky,
  output logic                       err_pulse
);

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (&v) ? v : v + CNT_WIDTH'(1);
  endfunction

  mon_state_t                 state_q, state_d;
  logic                       in_frame_q, in_frame_d;
  logic                       frame_done_q, frame_done_d;
  logic [FRAME_CNT_WIDTH-1:0] frame_count_q, frame_count_d;
  logic [CNT_WIDTH-1:0]       last_line_beats_q, last_line_beats_d;
  logic [CNT_WIDTH-1:0]       last_frame_lines_q, last_frame_lines_d;
  logic [AXIS_DATA_WIDTH-1:0] frame_checksum_q, frame_checksum_d;
  logic [AXIS_DATA_WIDTH-1:0] acc_q, acc_d;
  logic [ERR_W-1:0]           err_sticky_q, err_sticky_d;
  logic                       err_pulse_q, err_pulse_d;

  logic beat, active, sof, eof, sol, eol_u, eol;
  logic start, cont, counted, line_end, frame_end, timeout;
  logic [CNT_WIDTH-1:0] beat_cnt, line_cnt, stall_cnt;
  logic [CNT_WIDTH-1:0] beats_this_line, lines_this_frame;
  logic [ERR_W-1:0]     new_err;

  assign beat   = s_axis_tvalid & s_axis_tready & cfg_enable;
  assign active = (state_q != IDLE);
  assign sof    = s_axis_tuser[TUSER_SOF];
  assign eof    = s_axis_tuser[TUSER_EOF];
  assign sol    = s_axis_tuser[TUSER_SOL];
  assign eol_u  = s_axis_tuser[TUSER_EOL];
  // EOF without EOL still closes the line.
  assign eol    = eol_u | eof;

  // start: SOF beat from any state (restarts the frame); cont: in-frame beat.
  assign start     = beat & sof;
  assign cont      = beat & active & ~sof;
  assign counted   = start | cont;
  assign line_end  = counted & eol;
  assign frame_end = counted & eof;

  // The beat counter holds beats already seen in this line, so the closing
  // beat adds one; an SOF beat is always the first beat of line one.
  assign beats_this_line  = sof ? CNT_WIDTH'(1) : sat_inc(beat_cnt);
  assign lines_this_frame = sof ? CNT_WIDTH'(1) : sat_inc(line_cnt);

  assign timeout = cfg_enable & active & ~beat & (cfg_timeout != '0) &
                   (sat_inc(stall_cnt) == cfg_timeout);

  always_comb begin
    new_err = '0;
    new_err[ERR_SOF_UNEXPECTED]     = start & active;
    new_err[ERR_DATA_OUTSIDE_FRAME] = beat & ~active & ~sof;
    new_err[ERR_LINE_LENGTH]        = line_end &
                                      ((beats_this_line != cfg_line_beats) | (eof & ~eol_u));
    new_err[ERR_LINE_COUNT]         = frame_end & (lines_this_frame != cfg_frame_lines);
    new_err[ERR_TLAST_MISMATCH]     = beat & (s_axis_tlast != eol_u);
    new_err[ERR_TIMEOUT]            = timeout;
    new_err[ERR_SOL_MISSING]        = cont & (state_q == GAP) & ~sol;
  end

  axis_mon_sat_counter #(.W(CNT_WIDTH)) u_beat_cnt (
    .clk_i (aclk),
    .rst_i (aclk_reset),
    .clr_i (line_end),
    .ld1_i (start),
    .inc_i (cont),
    .q_o   (beat_cnt)
  );

  axis_mon_sat_counter #(.W(CNT_WIDTH)) u_line_cnt (
    .clk_i (aclk),
    .rst_i (aclk_reset),
    .clr_i (start & ~eol),
    .ld1_i (start & eol),
    .inc_i (cont & eol),
    .q_o   (line_cnt)
  );

  axis_mon_sat_counter #(.W(CNT_WIDTH)) u_stall_cnt (
    .clk_i (aclk),
    .rst_i (aclk_reset),
    .clr_i (~cfg_enable | ~active | beat | timeout | (cfg_timeout == '0)),
    .ld1_i (1'b0),
    .inc_i (1'b1),
    .q_o   (stall_cnt)
  );

  always_comb begin
    state_d            = state_q;
    acc_d              = acc_q;
    frame_done_d       = 1'b0;
    frame_count_d      = frame_count_q;
    last_line_beats_d  = last_line_beats_q;
    last_frame_lines_d = last_frame_lines_q;
    frame_checksum_d   = frame_checksum_q;

    if (start)     acc_d = s_axis_tdata;
    else if (cont) acc_d = acc_q ^ s_axis_tdata;

    if (line_end) last_line_beats_d = beats_this_line;

    if (frame_end) begin
      last_frame_lines_d = lines_this_frame;
      frame_checksum_d   = acc_d;
      frame_count_d      = frame_count_q + FRAME_CNT_WIDTH'(1);
      frame_done_d       = 1'b1;
    end

    if (!cfg_enable)    state_d = IDLE;
    else if (frame_end) state_d = IDLE;
    else if (line_end)  state_d = GAP;
    else if (counted)   state_d = LINE;
    else if (timeout)   state_d = IDLE;

    in_frame_d   = (state_d != IDLE);
    err_sticky_d = (err_clear ? '0 : err_sticky_q) | new_err;
    err_pulse_d  = |(new_err & ~err_sticky_q);
  end

  always_ff @(posedge aclk) begin
    if (aclk_reset) begin
      state_q            <= IDLE;
      in_frame_q         <= 1'b0;
      frame_done_q       <= 1'b0;
      frame_count_q      <= '0;
      last_line_beats_q  <= '0;
      last_frame_lines_q <= '0;
      frame_checksum_q   <= '0;
      acc_q              <= '0;
      err_sticky_q       <= '0;
      err_pulse_q        <= 1'b0;
    end else begin
      state_q            <= state_d;
      in_frame_q         <= in_frame_d;
      frame_done_q       <= frame_done_d;
      frame_count_q      <= frame_count_d;
      last_line_beats_q  <= last_line_beats_d;
      last_frame_lines_q <= last_frame_lines_d;
      frame_checksum_q   <= frame_checksum_d;
      acc_q              <= acc_d;
      err_sticky_q       <= err_sticky_d;
      err_pulse_q        <= err_pulse_d;
    end
  end

  assign in_frame         = in_frame_q;
  assign frame_done       = frame_done_q;
  assign frame_count      = frame_count_q;
  assign last_line_beats  = last_line_beats_q;
  assign last_frame_lines = last_frame_lines_q;
  assign frame_checksum   = frame_checksum_q;
  assign err_sticky       = err_sticky_q;
  assign err_pulse        = err_pulse_q;

endmodule

// File: tb/tb_axis_frame_monitor.sv
// Self-checking bench for axis_frame_monitor. Frames are generated from a
// geometry description; expectations (checksum, counts, error bits) come
// from that description, not from the design.
module tb_axis_frame_monitor;

  logic        aclk = 1'b0;
  logic        aclk_reset;
  logic        s_axis_tvalid, s_axis_tready, s_axis_tlast;
  logic [63:0] s_axis_tdata;
  logic [3:0]  s_axis_tuser;
  logic        cfg_enable;
  logic [15:0] cfg_line_beats, cfg_frame_lines, cfg_timeout;
  logic        err_clear;
  logic        in_frame, frame_done, err_pulse;
  logic [31:0] frame_count;
  logic [15:0] last_line_beats, last_frame_lines;
  logic [63:0] frame_checksum;
  logic [6:0]  err_sticky;

  int n_chk  = 0;
  int n_fail = 0;
  int done_cnt = 0;
  int ep_cnt   = 0;

  axis_frame_monitor dut (
    .aclk             (aclk),
    .aclk_reset       (aclk_reset),
    .s_axis_tvalid    (s_axis_tvalid),
    .s_axis_tready    (s_axis_tready),
    .s_axis_tdata     (s_axis_tdata),
    .s_axis_tuser     (s_axis_tuser),
    .s_axis_tlast     (s_axis_tlast),
    .cfg_enable       (cfg_enable),
    .cfg_line_beats   (cfg_line_beats),
    .cfg_frame_lines  (cfg_frame_lines),
    .cfg_timeout      (cfg_timeout),
    .err_clear        (err_clear),
    .in_frame         (in_frame),
    .frame_done       (frame_done),
    .frame_count      (frame_count),
    .last_line_beats  (last_line_beats),
    .last_frame_lines (last_frame_lines),
    .frame_checksum   (frame_checksum),
    .err_sticky       (err_sticky),
    .err_pulse        (err_pulse)
  );

  always #5 aclk = ~aclk;

  always @(negedge aclk) begin
    if (frame_done === 1'b1) done_cnt++;
    if (err_pulse === 1'b1)  ep_cnt++;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic do_reset();
    s_axis_tvalid = 0; s_axis_tready = 0; s_axis_tdata = '0;
    s_axis_tuser = '0; s_axis_tlast = 0;
    cfg_enable = 1; cfg_line_beats = 16'd8; cfg_frame_lines = 16'd4;
    cfg_timeout = 16'd0; err_clear = 0;
    aclk_reset = 1;
    tick(); tick();
    aclk_reset = 0;
  endtask

  // Random non-beat cycles, then one handshake beat; returns 1ns after it.
  task automatic drive_beat(input logic [63:0] d, input logic [3:0] u,
                            input logic l, input int max_stall);
    int n, r;
    n = $urandom_range(0, max_stall);
    for (int i = 0; i < n; i++) begin
      r = $urandom_range(0, 2);
      s_axis_tvalid = (r == 1); s_axis_tready = (r == 2);
      s_axis_tdata = {$urandom, $urandom}; s_axis_tuser = 4'($urandom);
      s_axis_tlast = 1'($urandom);
      tick();
    end
    s_axis_tvalid = 1; s_axis_tready = 1;
    s_axis_tdata = d; s_axis_tuser = u; s_axis_tlast = l;
    tick();
    s_axis_tvalid = 0; s_axis_tready = 0;
  endtask

  // Well-formed frame of nl lines x nb beats; line short_line gets nb-1 beats.
  task automatic send_frame(input int nl, input int nb, input int short_line,
                            input int max_stall, output logic [63:0] csum);
    logic [63:0] d;
    logic [3:0]  u;
    int len;
    csum = '0;
    for (int l = 0; l < nl; l++) begin
      len = (l == short_line) ? nb - 1 : nb;
      for (int b = 0; b < len; b++) begin
        d = {$urandom, $urandom};
        u = '0;
        u[0] = (l == 0 && b == 0);
        u[2] = (b == 0);
        u[3] = (b == len - 1);
        u[1] = (l == nl - 1 && b == len - 1);
        csum ^= d;
        drive_beat(d, u, u[3], max_stall);
        if (l == 0 && b == 0 && !u[1]) begin
          if (in_frame !== 1'b1) begin n_fail++; $display("FAIL in_frame_after_sof: got %0b want 1", in_frame); end
          n_chk++;
        end
        if (l == short_line && u[3]) begin
          if (last_line_beats !== 16'(len)) begin n_fail++; $display("FAIL short_line_beats: got %0d want %0d", last_line_beats, len); end
          n_chk++;
        end
      end
    end
    if (in_frame !== 1'b0) begin n_fail++; $display("FAIL in_frame_after_eof: got %0b want 0", in_frame); end
    n_chk++;
  endtask

  task automatic test_reset();
    logic [63:0] d;
    do_reset();
    if (frame_count !== 32'd0)      begin n_fail++; $display("FAIL rst_frame_count: got %0d want 0", frame_count); end n_chk++;
    if (err_sticky !== 7'd0)        begin n_fail++; $display("FAIL rst_err_sticky: got %0h want 0", err_sticky); end n_chk++;
    if ({in_frame, frame_done, err_pulse} !== 3'b000) begin n_fail++; $display("FAIL rst_flags: got %0b want 000", {in_frame, frame_done, err_pulse}); end n_chk++;
    if ({last_line_beats, last_frame_lines} !== 32'd0) begin n_fail++; $display("FAIL rst_geom: got %0h want 0", {last_line_beats, last_frame_lines}); end n_chk++;
    if (frame_checksum !== 64'd0)   begin n_fail++; $display("FAIL rst_checksum: got %0h want 0", frame_checksum); end n_chk++;
    d = {$urandom, $urandom};
    drive_beat(d, 4'h5, 1'b0, 0);
    drive_beat(d, 4'h0, 1'b0, 0);
    aclk_reset = 1; tick(); aclk_reset = 0;
    if (in_frame !== 1'b0 || err_sticky !== 7'd0) begin n_fail++; $display("FAIL midframe_reset: got in_frame=%0b err=%0h want 0/0", in_frame, err_sticky); end n_chk++;
  endtask

  task automatic test_clean_frames();
    logic [63:0] cs;
    int d0;
    do_reset();
    d0 = done_cnt;
    for (int f = 0; f < 3; f++) send_frame(4, 8, -1, 3, cs);
    tick();
    if (frame_count !== 32'd3)        begin n_fail++; $display("FAIL clean_frame_count: got %0d want 3", frame_count); end n_chk++;
    if (last_line_beats !== 16'd8)    begin n_fail++; $display("FAIL clean_line_beats: got %0d want 8", last_line_beats); end n_chk++;
    if (last_frame_lines !== 16'd4)   begin n_fail++; $display("FAIL clean_frame_lines: got %0d want 4", last_frame_lines); end n_chk++;
    if (err_sticky !== 7'd0)          begin n_fail++; $display("FAIL clean_err: got %0h want 0", err_sticky); end n_chk++;
    if (frame_checksum !== cs)        begin n_fail++; $display("FAIL clean_checksum: got %0h want %0h", frame_checksum, cs); end n_chk++;
    if (done_cnt - d0 !== 3)          begin n_fail++; $display("FAIL clean_done_pulses: got %0d want 3", done_cnt - d0); end n_chk++;
  endtask

  task automatic test_line_length();
    logic [63:0] cs;
    int e0;
    do_reset();
    e0 = ep_cnt;
    send_frame(4, 8, 1, 2, cs);
    tick();
    if (err_sticky !== 7'h04)       begin n_fail++; $display("FAIL linelen_err: got %0h want 04", err_sticky); end n_chk++;
    if (ep_cnt - e0 !== 1)          begin n_fail++; $display("FAIL linelen_pulses: got %0d want 1", ep_cnt - e0); end n_chk++;
    if (frame_count !== 32'd1)      begin n_fail++; $display("FAIL linelen_frames: got %0d want 1", frame_count); end n_chk++;
    if (frame_checksum !== cs)      begin n_fail++; $display("FAIL linelen_checksum: got %0h want %0h", frame_checksum, cs); end n_chk++;
  endtask

  task automatic test_sof_inject();
    logic [63:0] cs;
    do_reset();
    drive_beat({$urandom, $urandom}, 4'h5, 1'b0, 2);
    for (int i = 0; i < 3; i++) drive_beat({$urandom, $urandom}, 4'h0, 1'b0, 2);
    send_frame(4, 8, -1, 2, cs);
    if (err_sticky !== 7'h01)       begin n_fail++; $display("FAIL sofinj_err: got %0h want 01", err_sticky); end n_chk++;
    if (last_frame_lines !== 16'd4) begin n_fail++; $display("FAIL sofinj_lines: got %0d want 4", last_frame_lines); end n_chk++;
    if (frame_count !== 32'd1)      begin n_fail++; $display("FAIL sofinj_frames: got %0d want 1", frame_count); end n_chk++;
    if (frame_checksum !== cs)      begin n_fail++; $display("FAIL sofinj_checksum: got %0h want %0h", frame_checksum, cs); end n_chk++;
  endtask

  task automatic test_timeout();
    do_reset();
    cfg_timeout = 16'd20;
    drive_beat({$urandom, $urandom}, 4'h5, 1'b0, 3);
    drive_beat({$urandom, $urandom}, 4'h0, 1'b0, 3);
    drive_beat({$urandom, $urandom}, 4'h0, 1'b0, 3);
    repeat (19) tick();
    if (err_sticky[5] !== 1'b0 || in_frame !== 1'b1) begin n_fail++; $display("FAIL timeout_early: got err5=%0b in_frame=%0b want 0/1", err_sticky[5], in_frame); end n_chk++;
    tick();
    if (err_sticky !== 7'h20)       begin n_fail++; $display("FAIL timeout_err: got %0h want 20", err_sticky); end n_chk++;
    if (in_frame !== 1'b0)          begin n_fail++; $display("FAIL timeout_in_frame: got %0b want 0", in_frame); end n_chk++;
    if (err_pulse !== 1'b1)         begin n_fail++; $display("FAIL timeout_pulse: got %0b want 1", err_pulse); end n_chk++;
    if (frame_count !== 32'd0)      begin n_fail++; $display("FAIL timeout_frames: got %0d want 0", frame_count); end n_chk++;
    repeat (5) tick();
    drive_beat({$urandom, $urandom}, 4'h0, 1'b0, 0);
    if (err_sticky !== 7'h22)       begin n_fail++; $display("FAIL timeout_outside: got %0h want 22", err_sticky); end n_chk++;
  endtask

  task automatic test_tlast_clear();
    do_reset();
    cfg_line_beats = 16'd4; cfg_frame_lines = 16'd1;
    drive_beat({$urandom, $urandom}, 4'h5, 1'b0, 2);
    drive_beat({$urandom, $urandom}, 4'h0, 1'b0, 2);
    drive_beat({$urandom, $urandom}, 4'h0, 1'b0, 2);
    drive_beat({$urandom, $urandom}, 4'hA, 1'b0, 2);
    if (err_sticky !== 7'h10)       begin n_fail++; $display("FAIL tlast_err: got %0h want 10", err_sticky); end n_chk++;
    if (frame_count !== 32'd1)      begin n_fail++; $display("FAIL tlast_frames: got %0d want 1", frame_count); end n_chk++;
    err_clear = 1;
    drive_beat({$urandom, $urandom}, 4'h5, 1'b1, 0);
    err_clear = 0;
    if (err_sticky !== 7'h10)       begin n_fail++; $display("FAIL clear_vs_set: got %0h want 10", err_sticky); end n_chk++;
    if (err_pulse !== 1'b0)         begin n_fail++; $display("FAIL clear_vs_set_pulse: got %0b want 0", err_pulse); end n_chk++;
    err_clear = 1; tick(); err_clear = 0;
    if (err_sticky !== 7'h00)       begin n_fail++; $display("FAIL clear_alone: got %0h want 00", err_sticky); end n_chk++;
  endtask

  task automatic test_single_beat();
    do_reset();
    cfg_line_beats = 16'd1; cfg_frame_lines = 16'd1;
    drive_beat(64'hA5, 4'hF, 1'b1, 2);
    if (frame_count !== 32'd1)      begin n_fail++; $display("FAIL single_frames: got %0d want 1", frame_count); end n_chk++;
    if (frame_checksum !== 64'hA5)  begin n_fail++; $display("FAIL single_checksum: got %0h want a5", frame_checksum); end n_chk++;
    if (err_sticky !== 7'd0)        begin n_fail++; $display("FAIL single_err: got %0h want 0", err_sticky); end n_chk++;
    if (frame_done !== 1'b1)        begin n_fail++; $display("FAIL single_done: got %0b want 1", frame_done); end n_chk++;
    if ({last_line_beats, last_frame_lines} !== {16'd1, 16'd1}) begin n_fail++; $display("FAIL single_geom: got %0h want 00010001", {last_line_beats, last_frame_lines}); end n_chk++;
  endtask

  task automatic test_disable();
    do_reset();
    cfg_line_beats = 16'd1; cfg_frame_lines = 16'd1;
    cfg_enable = 0;
    drive_beat({$urandom, $urandom}, 4'hF, 1'b1, 0);
    if (frame_count !== 32'd0 || err_sticky !== 7'd0) begin n_fail++; $display("FAIL disabled_ignore: got fc=%0d err=%0h want 0/0", frame_count, err_sticky); end n_chk++;
    cfg_enable = 1; cfg_line_beats = 16'd4;
    drive_beat({$urandom, $urandom}, 4'h5, 1'b0, 0);
    if (in_frame !== 1'b1)          begin n_fail++; $display("FAIL enable_sof: got %0b want 1", in_frame); end n_chk++;
    cfg_enable = 0; tick();
    if (in_frame !== 1'b0)          begin n_fail++; $display("FAIL disable_idle: got %0b want 0", in_frame); end n_chk++;
    cfg_enable = 1;
    drive_beat({$urandom, $urandom}, 4'h0, 1'b0, 0);
    if (err_sticky !== 7'h02)       begin n_fail++; $display("FAIL reenable_outside: got %0h want 02", err_sticky); end n_chk++;
    cfg_enable = 0; repeat (3) tick();
    if (err_sticky !== 7'h02)       begin n_fail++; $display("FAIL disable_hold_err: got %0h want 02", err_sticky); end n_chk++;
    cfg_enable = 1;
  endtask

  task automatic test_back_to_back();
    logic [63:0] cs;
    int nl, nb;
    do_reset();
    for (int f = 0; f < 6; f++) begin
      nb = $urandom_range(1, 6);
      nl = $urandom_range(1, 4);
      cfg_line_beats = 16'(nb); cfg_frame_lines = 16'(nl);
      send_frame(nl, nb, -1, (f % 2) * 2, cs);
      if (frame_count !== 32'(f + 1)) begin n_fail++; $display("FAIL b2b_frames: got %0d want %0d", frame_count, f + 1); end n_chk++;
      if (frame_checksum !== cs)      begin n_fail++; $display("FAIL b2b_checksum: got %0h want %0h", frame_checksum, cs); end n_chk++;
      if (last_line_beats !== 16'(nb) || last_frame_lines !== 16'(nl)) begin n_fail++; $display("FAIL b2b_geom: got %0dx%0d want %0dx%0d", last_line_beats, last_frame_lines, nb, nl); end n_chk++;
      if (err_sticky !== 7'd0)        begin n_fail++; $display("FAIL b2b_err: got %0h want 0", err_sticky); end n_chk++;
    end
  endtask

  initial begin
    test_reset();
    test_clean_frames();
    test_line_length();
    test_sof_inject();
    test_timeout();
    test_tlast_clear();
    test_single_beat();
    test_disable();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/axis_frame_monitor.md
Name: axis_frame_monitor

Overview:
- Passive AXI4-Stream video frame monitor for the XGS Athena validation environment.
- Sniffs the image output stream (tdata/tuser/tlast/tvalid/tready) without driving any stream signal.
- Checks frame and line structure against programmed geometry, counts frames and flags protocol errors.
- Parametrised successor of the fixed 64-bit/4-user stream hookup. Runtime geometry replaces hard-coded test expectations; a stall watchdog is added.

Parameters:
- AXIS_DATA_WIDTH, 64: sniffed tdata width (checksum only).
- AXIS_USER_WIDTH, 4: tuser width, >=4. Bit 0 = SOF, 1 = EOF, 2 = SOL, 3 = EOL; upper bits ignored.
- CNT_WIDTH, 16: width of beat, line and timeout counters and their cfg inputs.
- FRAME_CNT_WIDTH, 32: width of frame_count.

Ports:
- aclk  in  1  single clock.
- aclk_reset  in  1  synchronous, active-high reset.
- s_axis_tvalid  in  1  sniffed.
- s_axis_tready  in  1  sniffed.
- s_axis_tdata  in  AXIS_DATA_WIDTH  sniffed.
- s_axis_tuser  in  AXIS_USER_WIDTH  sniffed.
- s_axis_tlast  in  1  sniffed.
- cfg_enable  in  1  monitor enable; 0 forces IDLE and freezes counters.
- cfg_line_beats  in  CNT_WIDTH  expected beats per line, >=1.
- cfg_frame_lines  in  CNT_WIDTH  expected lines per frame, >=1.
- cfg_timeout  in  CNT_WIDTH  stall limit in cycles; 0 = watchdog off.
- err_clear  in  1  one-cycle pulse; clears err_sticky.
- in_frame  out  1  high from SOF beat until EOF beat.
- frame_done  out  1  one-cycle pulse, cycle after the EOF beat.
- frame_count  out  FRAME_CNT_WIDTH  completed frames; wraps.
- last_line_beats  out  CNT_WIDTH  beat count of most recent line.
- last_frame_lines  out  CNT_WIDTH  line count of most recent frame.
- frame_checksum  out  AXIS_DATA_WIDTH  XOR of all tdata beats of the last completed frame.
- err_sticky  out  7  sticky error flags, bit map under Behaviour.
- err_pulse  out  1  one-cycle pulse when any error bit newly sets.

Behaviour:
- Beat = s_axis_tvalid & s_axis_tready, sampled at the posedge of aclk. All outputs are registered.
- Reset values: every output and counter is 0; state = IDLE.
- FSM states: IDLE, LINE, GAP.
  - IDLE: beat with SOF goes to LINE. Any other beat sets err[1] (data outside frame).
  - LINE: counts beats; on EOL beat goes to GAP.
  - GAP: a beat without SOL sets err[6], but the beat is still counted as the start of a new line; goes to LINE. A beat that is SOL and EOL (single-beat line) stays in GAP.
- SOF beat (including one seen while LINE or GAP):
  - SOF received while in LINE or GAP sets err[0]; the monitor restarts the frame at that beat.
  - On SOF: checksum := tdata, beat_cnt := 1, line_cnt := 0.
  - SOF also implies SOL.
- EOL beat:
  - beats_this_line = beat_cnt + 1, saturating at 2^CNT_WIDTH-1.
  - Loaded into last_line_beats; compared with cfg_line_beats, mismatch sets err[2].
  - line_cnt increments (saturating).
- tlast != tuser[3] on any beat sets err[4]. The EOL decision uses tuser[3] only.
- EOF beat:
  - Must coincide with EOL; EOF without EOL sets err[2] and is treated as EOL.
  - last_frame_lines := final line_cnt; mismatch with cfg_frame_lines sets err[3].
  - frame_checksum := accumulated XOR including this beat.
  - frame_count += 1 (wraps); frame_done pulses next cycle; state -> IDLE.
  - SOF and EOF on the same beat form a one-line, one-beat frame; both actions apply in order SOF then EOF.
- Watchdog: in LINE or GAP with cfg_timeout != 0, stall_cnt increments on each cycle without a beat and resets on each beat. When stall_cnt == cfg_timeout, err[5] sets and state -> IDLE; frame_count is not incremented.
- err_sticky bit map: 0 sof_unexpected, 1 data_outside_frame, 2 line_length, 3 line_count, 4 tlast_mismatch, 5 timeout, 6 sol_missing.
- err_pulse = OR over bits of (new_set & ~err_sticky_prev).
- err_clear: clears err_sticky. If an error sets in the same cycle, set wins.
- cfg_enable = 0: state -> IDLE, stall_cnt := 0; err_sticky and frame_count are held. Re-enable mid-frame waits for the next SOF; those beats flag err[1].
- Reset mid-frame returns everything to reset values; no error is flagged.
- cfg inputs are quasi-static. Changes take effect at the next comparison.

Decomposition:
- Shared package axis_mon_pkg holds:
  - tuser bit index constants TUSER_SOF=0, TUSER_EOF=1, TUSER_SOL=2, TUSER_EOL=3.
  - enum typedef mon_state_t {IDLE, LINE, GAP}.
  - err bit index constants.
- One natural sub-module: axis_mon_sat_counter, a parametrised saturating counter with clear, load-1 and increment. Instantiated for beat_cnt, line_cnt and stall_cnt.

Test Plan:
- cfg 8 beats x 4 lines, 3 clean frames with random tready stalls -> frame_count=3, last_line_beats=8, last_frame_lines=4, err_sticky=0, three frame_done pulses.
- Line 2 has 7 beats -> err[2] sets, err_pulse once, last_line_beats=7; frame still counted, frame_count=1.
- SOF injected on beat 5 of line 1 -> err[0]=1; the following clean frame completes with last_frame_lines=4.
- cfg_timeout=20, stream stalls 25 cycles mid-line -> err[5] sets on the 20th idle cycle, in_frame=0, frame_count unchanged; next beat without SOF sets err[1].
- tlast held low on an EOL beat, then err_clear pulsed in the same cycle as a new error -> err[4] set; clear with simultaneous set keeps the bit at 1.
- Single-beat frame (tuser=4'hF, tlast=1, tdata=64'hA5) with cfg 1x1 -> frame_count=1, frame_checksum=64'hA5, err_sticky=0.
